branch_controller: RTL and testbench

BRANCH_CONTROLLER -- requirements
Module: branch_controller

---
 rtl/branch_pkg.sv | 12 +
 rtl/branch_comparator.sv | 38 +++
 rtl/branch_controller.sv | 48 ++++
 tb/tb_branch_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared constants for the branch controller: RISC-V branch func3 encodings.
package branch_pkg;

  // Conditional-branch func3 encodings; 3'b010 and 3'b011 are reserved.
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

endpackage : branch_pkg

// File: rtl/branch_comparator.sv
// Combinational branch-condition evaluator: decodes func3 and compares the
// two register operands over the full XLEN, signed or unsigned.
module branch_comparator
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [2:0]      func3,
  output logic            condition
);

  logic eq;
  logic lt_signed;
  logic lt_unsigned;

  assign eq          = (data1 == data2);
  assign lt_signed   = ($signed(data1) < $signed(data2));
  assign lt_unsigned = (data1 < data2);

  // Select the comparison named by func3; reserved encodings never branch.
  always_comb begin
    // NOTE: default assigned before the case so every path drives condition
    // and no latch is inferred for the reserved encodings.
    condition = 1'b0;
    case (func3)
      BEQ:     condition = eq;
      BNE:     condition = !eq;
      BLT:     condition = lt_signed;
      BGE:     condition = !lt_signed;
      BLTU:    condition = lt_unsigned;
      BGEU:    condition = !lt_unsigned;
      default: condition = 1'b0;
    endcase
  end

endmodule : branch_comparator

// File: rtl/branch_controller.sv
// Branch/jump redirect unit: gates the branch condition with the Branch and
// Jump qualifiers and registers the PC-select and redirect target.
module branch_controller
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] data1,
  input  logic [XLEN-1:0] data2,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] ALUresult,
  input  logic            Branch,
  input  logic            Jump,
  output logic [XLEN-1:0] TargetedAddress,
  output logic            PCAddressController
);

  logic condition;
  logic taken;

  branch_comparator #(
    .XLEN (XLEN)
  ) u_comparator (
    .data1     (data1),
    .data2     (data2),
    .func3     (func3),
    .condition (condition)
  );

  // Jumps always redirect; branches redirect only when their condition holds.
  assign taken = Jump | (Branch & condition);

  // Register the redirect decision and target every cycle; the target is
  // captured unconditionally and is only meaningful when PCAddressController is set.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PCAddressController <= 1'b0;
      TargetedAddress     <= '0;
    end else begin
      // NOTE: non-blocking assignments so both registers sample pre-edge values.
      PCAddressController <= taken;
      TargetedAddress     <= ALUresult;
    end
  end

endmodule : branch_controller

// File: tb/tb_branch_controller.sv
// Self-checking bench for branch_controller: directed cases plus random
// stimulus, with expected responses queued by the driver and compared by an
// independent monitor one cycle later.
module tb_branch_controller;

  localparam int XLEN = 32;

  logic            CLK;
  logic            RESET;
  logic [XLEN-1:0] data1;
  logic [XLEN-1:0] data2;
  logic [2:0]      func3;
  logic [XLEN-1:0] ALUresult;
  logic            Branch;
  logic            Jump;
  logic [XLEN-1:0] TargetedAddress;
  logic            PCAddressController;

  typedef struct {
    logic            taken;
    logic [XLEN-1:0] target;
    string           name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  branch_controller #(
    .XLEN (XLEN)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .data1               (data1),
    .data2               (data2),
    .func3               (func3),
    .ALUresult           (ALUresult),
    .Branch              (Branch),
    .Jump                (Jump),
    .TargetedAddress     (TargetedAddress),
    .PCAddressController (PCAddressController)
  );

  // 10 ns clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: RISC-V branch semantics evaluated with wide integer
  // arithmetic on sign- and zero-extended operands.
  function automatic logic model_taken(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                       input logic [2:0] f, input logic br, input logic jp);
    longint sa, sb, ua, ub;
    logic   cond;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({1'b0, a});
    ub = longint'({1'b0, b});
    case (f)
      3'd0:    cond = (ua == ub);
      3'd1:    cond = (ua != ub);
      3'd4:    cond = (sa <  sb);
      3'd5:    cond = (sa >= sb);
      3'd6:    cond = (ua <  ub);
      3'd7:    cond = (ua >= ub);
      default: cond = 1'b0;
    endcase
    if (jp) return 1'b1;
    return br & cond;
  endfunction

  // Drive one cycle of stimulus (with reset released) and queue its response.
  task automatic apply(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [2:0] f, input logic [XLEN-1:0] alu,
                       input logic br, input logic jp);
    exp_t e;
    @(negedge CLK);
    RESET     = 1'b1;
    data1     = a;
    data2     = b;
    func3     = f;
    ALUresult = alu;
    Branch    = br;
    Jump      = jp;
    e.taken   = model_taken(a, b, f, br, jp);
    e.target  = alu;
    e.name    = name;
    exp_q.push_back(e);
  endtask

  // Monitor: one cycle after stimulus, compare the registered outputs.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".pc_sel"}, 64'(PCAddressController), 64'(e.taken));
        check({e.name, ".target"}, 64'(TargetedAddress), 64'(e.target));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Directed expectations written out explicitly for the spec scenarios.
  task automatic expect_taken(input string name, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [2:0] f, input logic [XLEN-1:0] alu,
                              input logic br, input logic jp, input logic want);
    check({name, ".model"}, 64'(model_taken(a, b, f, br, jp)), 64'(want));
    apply(name, a, b, f, alu, br, jp);
  endtask

  initial begin
    logic [XLEN-1:0] a, b, alu;
    logic [2:0]      f;
    logic            br, jp;

    // Held in reset with a jump presented: outputs must stay zero across edges.
    RESET = 1'b0; data1 = 32'd5; data2 = 32'd5; func3 = 3'b000;
    ALUresult = 32'hDEAD_BEE0; Branch = 1'b1; Jump = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("reset.pc_sel", 64'(PCAddressController), 64'd0);
    check("reset.target", 64'(TargetedAddress), 64'd0);

    // Signed less-than then greater-or-equal.
    expect_taken("blt_12_15", 32'd12, 32'd15, 3'b100, 32'd24, 1'b1, 1'b0, 1'b1);
    expect_taken("bge_12_15", 32'd12, 32'd15, 3'b101, 32'd24, 1'b1, 1'b0, 1'b0);
    // Equality.
    expect_taken("beq_15_15", 32'd15, 32'd15, 3'b000, 32'd40, 1'b1, 1'b0, 1'b1);
    expect_taken("bne_15_15", 32'd15, 32'd15, 3'b001, 32'd40, 1'b1, 1'b0, 1'b0);
    // Signed versus unsigned with -15 vs 15.
    expect_taken("bge_m15_15",  32'hFFFF_FFF1, 32'd15, 3'b101, 32'h100, 1'b1, 1'b0, 1'b0);
    expect_taken("bgeu_m15_15", 32'hFFFF_FFF1, 32'd15, 3'b111, 32'h104, 1'b1, 1'b0, 1'b1);
    expect_taken("bltu_m15_15", 32'hFFFF_FFF1, 32'd15, 3'b110, 32'h108, 1'b1, 1'b0, 1'b0);
    expect_taken("blt_m15_15",  32'hFFFF_FFF1, 32'd15, 3'b100, 32'h10C, 1'b1, 1'b0, 1'b1);
    // Extreme signed values.
    expect_taken("blt_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 3'b100, 32'h200, 1'b1, 1'b0, 1'b1);
    expect_taken("bltu_min_max", 32'h8000_0000, 32'h7FFF_FFFF, 3'b110, 32'h204, 1'b1, 1'b0, 1'b0);
    // Jump priority and branch gating.
    expect_taken("jump_nobr", 32'd1, 32'd2, 3'b000, 32'hCAFE_0000, 1'b0, 1'b1, 1'b1);
    expect_taken("jump_rsvd", 32'd1, 32'd1, 3'b010, 32'hCAFE_0004, 1'b1, 1'b1, 1'b1);
    expect_taken("nobranch",  32'd7, 32'd7, 3'b000, 32'hCAFE_0008, 1'b0, 1'b0, 1'b0);
    // Reserved encodings.
    expect_taken("rsvd_010", 32'd7, 32'd7, 3'b010, 32'h300, 1'b1, 1'b0, 1'b0);
    expect_taken("rsvd_011", 32'd1, 32'd9, 3'b011, 32'h304, 1'b1, 1'b0, 1'b0);

    // Randomized stimulus.
    for (int i = 0; i < 400; i++) begin
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'h8000_0000;
        2:       b = $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        logic [XLEN-1:0] t;
        t = a; a = b; b = t;
      end
      f   = 3'($urandom_range(0, 7));
      alu = $urandom;
      br  = 1'($urandom_range(0, 1));
      jp  = ($urandom_range(0, 4) == 0);
      apply($sformatf("rand%0d", i), a, b, f, alu, br, jp);
    end

    // Asynchronous reset mid-cycle while a jump is being taken.
    apply("pre_reset_jump", 32'd0, 32'd1, 3'b000, 32'h0000_ABC0, 1'b0, 1'b1);
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    check("async_reset.pc_sel", 64'(PCAddressController), 64'd0);
    check("async_reset.target", 64'(TargetedAddress), 64'd0);
    @(posedge CLK);
    #1;
    check("held_reset.pc_sel", 64'(PCAddressController), 64'd0);
    check("held_reset.target", 64'(TargetedAddress), 64'd0);
    // Release and present a jump: the first edge must register it.
    expect_taken("post_reset_jump", 32'd3, 32'd4, 3'b001, 32'h0000_1230, 1'b0, 1'b1, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int c = 0; c < 5 && exp_q.size() != 0; c++) @(posedge CLK);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_branch_controller
